// File: rtl/wb_lsu_master_pkg.sv
// Shared load/store constants for the Wishbone data-port initiator.
// funct3 encodings and access-size helper.
package wb_lsu_master_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: sel/store replication, misalign check,
// and load extraction with sign/zero extension.
module lsu_lane_align
  import wb_lsu_master_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  sel,
  output logic [31:0] dat_o,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_data,
  output logic [31:0] rdata
);

  lsu_size_t   sz;
  lsu_size_t   ld_sz;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign sz    = f3_size(funct3);
  assign ld_sz = f3_size(ld_funct3);
  assign ld_b  = ld_data[{ld_off, 3'b000} +: 8];
  assign ld_h  = ld_data[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    sel        = 4'b1111;
    dat_o      = wdata;
    misaligned = 1'b0;
    unique case (1'b1)
      sz == SZ_B: begin
        sel   = 4'b0001 << off;
        dat_o = {4{wdata[7:0]}};
      end
      sz == SZ_H: begin
        sel        = 4'b0011 << off;
        dat_o      = {2{wdata[15:0]}};
        misaligned = off[0];
      end
      default: misaligned = |off;
    endcase
  end

  // funct3[2] marks the unsigned load variants
  always_comb begin
    rdata = ld_data;
    unique case (1'b1)
      ld_sz == SZ_B: rdata = {{24{ld_b[7] & ~ld_funct3[2]}}, ld_b};
      ld_sz == SZ_H: rdata = {{16{ld_h[15] & ~ld_funct3[2]}}, ld_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone-classic data-port initiator: one load/store -> one bus cycle,
// with misalign detection, bus error and timeout handling.
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_misaligned,
  output logic [ADDR_W-1:0] dwb_adr_o,
  output logic [31:0]       dwb_dat_o,
  input  logic [31:0]       dwb_dat_i,
  output logic              dwb_we_o,
  output logic [3:0]        dwb_sel_o,
  output logic              dwb_cyc_o,
  output logic              dwb_stb_o,
  input  logic              dwb_ack_i,
  input  logic              dwb_err_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [TW-1:0] tmo_cnt;

  logic [3:0]  sel_c;
  logic [31:0] dat_c;
  logic        mis_c;
  logic [31:0] ld_rdata;
  logic        tmo_hit;

  lsu_lane_align u_align (
    .funct3     (req_funct3),
    .off        (req_addr[1:0]),
    .wdata      (req_wdata),
    .sel        (sel_c),
    .dat_o      (dat_c),
    .misaligned (mis_c),
    .ld_funct3  (f3_q),
    .ld_off     (off_q),
    .ld_data    (dwb_dat_i),
    .rdata      (ld_rdata)
  );

  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == T_LAST);
  assign dwb_stb_o = dwb_cyc_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      rsp_misaligned <= 1'b0;
      dwb_adr_o      <= '0;
      dwb_dat_o      <= '0;
      dwb_we_o       <= 1'b0;
      dwb_sel_o      <= '0;
      dwb_cyc_o      <= 1'b0;
      f3_q           <= '0;
      off_q          <= '0;
      we_q           <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            we_q      <= req_we;
            if (mis_c) begin
              state          <= S_RESP;
              rsp_valid      <= 1'b1;
              rsp_misaligned <= 1'b1;
            end else begin
              state     <= S_BUS;
              dwb_cyc_o <= 1'b1;
              dwb_we_o  <= req_we;
              dwb_sel_o <= sel_c;
              dwb_dat_o <= dat_c;
              dwb_adr_o <= {req_addr[ADDR_W-1:2], 2'b00};
              tmo_cnt   <= '0;
            end
          end
        end
        S_BUS: begin
          // err outranks ack; timeout only when the slave stays silent
          if (dwb_err_i || dwb_ack_i || tmo_hit) begin
            state     <= S_RESP;
            dwb_cyc_o <= 1'b0;
            dwb_we_o  <= 1'b0;
            dwb_sel_o <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= dwb_err_i | ~dwb_ack_i;
            rsp_rdata <= (dwb_err_i | ~dwb_ack_i | we_q) ? '0 : ld_rdata;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          state          <= S_IDLE;
          req_ready      <= 1'b1;
          rsp_valid      <= 1'b0;
          rsp_rdata      <= '0;
          rsp_err        <= 1'b0;
          rsp_misaligned <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Randomized bench for wb_lsu_master against a byte-level reference
// model and a scripted Wishbone slave.
module tb_wb_lsu_master;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_misaligned;
  logic [31:0] dwb_adr_o;
  logic [31:0] dwb_dat_o;
  logic [31:0] dwb_dat_i;
  logic        dwb_we_o;
  logic [3:0]  dwb_sel_o;
  logic        dwb_cyc_o;
  logic        dwb_stb_o;
  logic        dwb_ack_i;
  logic        dwb_err_i;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_lsu_master #(
    .TIMEOUT_CYCLES (TMO),
    .ADDR_W         (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .rsp_misaligned (rsp_misaligned),
    .dwb_adr_o      (dwb_adr_o),
    .dwb_dat_o      (dwb_dat_o),
    .dwb_dat_i      (dwb_dat_i),
    .dwb_we_o       (dwb_we_o),
    .dwb_sel_o      (dwb_sel_o),
    .dwb_cyc_o      (dwb_cyc_o),
    .dwb_stb_o      (dwb_stb_o),
    .dwb_ack_i      (dwb_ack_i),
    .dwb_err_i      (dwb_err_i)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // mode: 0 ack, 1 err, 2 ack+err, 3 silent slave
  task automatic xfer(input logic        we,
                      input logic [2:0]  f3,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input logic [31:0] rd,
                      input int          mode,
                      input int          waits);
    int n, off, k, cyc_n, exp_k, exp_cyc;
    bit mis, seen;
    logic [3:0]  esel;
    logic [31:0] edat, erd, tmp;
    off  = int'(addr % 4);
    n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis  = (off % n) != 0;
    esel = (n == 4) ? 4'hF : 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) edat[8*i +: 8] = wd[8*(i % n) +: 8];
    erd = 32'h0;
    if (!we && !mis && mode == 0) begin
      tmp = rd >> (8 * off);
      if (n == 1)
        erd = (f3[2] || !tmp[7]) ? {24'h0, tmp[7:0]} : {24'hFFFFFF, tmp[7:0]};
      else if (n == 2)
        erd = (f3[2] || !tmp[15]) ? {16'h0, tmp[15:0]} : {16'hFFFF, tmp[15:0]};
      else
        erd = rd;
    end
    exp_k   = mis ? 1 : (mode == 3) ? TMO + 1 : waits + 2;
    exp_cyc = mis ? 0 : (mode == 3) ? TMO : waits + 1;

    @(negedge clk);
    check("ready_pre", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    k = 0;
    cyc_n = 0;
    seen = 0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      dwb_ack_i  = 1'b0;
      dwb_err_i  = 1'b0;
      dwb_dat_i  = $urandom;
      check("stb_eq_cyc", {31'b0, dwb_stb_o}, {31'b0, dwb_cyc_o});
      if (dwb_cyc_o) begin
        cyc_n++;
        check("adr", dwb_adr_o, {addr[31:2], 2'b00});
        check("sel", {28'b0, dwb_sel_o}, {28'b0, esel});
        check("we", {31'b0, dwb_we_o}, {31'b0, we});
        if (we) check("dat_o", dwb_dat_o, edat);
        if (mode != 3 && cyc_n == waits + 1) begin
          dwb_ack_i = (mode != 1);
          dwb_err_i = (mode != 0);
          dwb_dat_i = rd;
        end
      end
      if (rsp_valid) begin
        seen = 1;
        check("rsp_cycle", k, exp_k);
        check("rdata", rsp_rdata, erd);
        check("err", {31'b0, rsp_err}, {31'b0, !mis && mode != 0});
        check("misaligned", {31'b0, rsp_misaligned}, {31'b0, mis});
        check("cyc_at_rsp", {31'b0, dwb_cyc_o}, 32'd0);
      end
    end
    if (!seen) check("rsp_never", 32'd0, 32'd1);
    req_valid = 1'b0;
    dwb_ack_i = 1'b0;
    dwb_err_i = 1'b0;
    check("cyc_len", cyc_n, exp_cyc);
    @(negedge clk);
    check("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
    check("ready_post", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h3000;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_cyc_pre", {31'b0, dwb_cyc_o}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_cyc", {31'b0, dwb_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, dwb_stb_o}, 32'd0);
    check("rst_rsp", {31'b0, rsp_valid}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      check("rst_no_cyc", {31'b0, dwb_cyc_o}, 32'd0);
    end
    check("rst_ready_post", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          mode;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    dwb_dat_i  = 32'h0;
    dwb_ack_i  = 1'b0;
    dwb_err_i  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    check("reset_cyc", {31'b0, dwb_cyc_o}, 32'd0);
    check("reset_we", {31'b0, dwb_we_o}, 32'd0);
    check("reset_sel", {28'b0, dwb_sel_o}, 32'd0);
    check("reset_adr", dwb_adr_o, 32'd0);
    check("reset_dat", dwb_dat_o, 32'd0);
    check("reset_rsp", {31'b0, rsp_valid}, 32'd0);

    xfer(1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 1);
    xfer(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF0000, 0, 1);
    xfer(1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF0000, 0, 1);
    xfer(1'b0, 3'b001, 32'h1002, 32'h0, 32'h80FF0000, 0, 1);
    xfer(1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'h0, 0, 1);
    xfer(1'b0, 3'b010, 32'h1001, 32'h0, 32'h0, 0, 1);
    xfer(1'b0, 3'b001, 32'h1003, 32'h0, 32'h0, 0, 1);
    xfer(1'b0, 3'b010, 32'h1004, 32'h0, 32'h12345678, 2, 0);
    xfer(1'b0, 3'b010, 32'h1008, 32'h0, 32'h12345678, 3, 0);

    // stray ack/err while idle must not produce a response
    @(negedge clk);
    dwb_ack_i = 1'b1;
    dwb_err_i = 1'b1;
    @(negedge clk);
    dwb_ack_i = 1'b0;
    dwb_err_i = 1'b0;
    check("idle_ack_rsp", {31'b0, rsp_valid}, 32'd0);
    check("idle_ack_cyc", {31'b0, dwb_cyc_o}, 32'd0);

    for (int t = 0; t < 150; t++) begin
      we   = 1'($urandom);
      f3   = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[0] = 1'b0;
      mode = ($urandom_range(0, 4) < 3) ? 0 : int'($urandom_range(1, 3));
      xfer(we, f3, addr, $urandom, $urandom, mode, int'($urandom_range(0, 2)));
    end

    reset_mid();
    xfer(1'b0, 3'b101, 32'h4002, 32'h0, 32'hF00D1234, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
